// File: rtl/apb_timer_slave.sv
// APB timer slave: zero-wait-state register file driving a prescaled down-counter
// with a write-1-to-clear interrupt flag and a registered level irq.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no transfer in flight
//  SETUP  | setup cycle seen; the current cycle is the access phase
//  ACCESS | access phase completed on the previous edge
module apb_timer_slave #(
    parameter int PRESCALE_W = 8
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    state_t                state_next;
    logic                  en;
    logic                  reload;
    logic                  ie;
    logic                  if_flag;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic [31:0]           load;
    logic [31:0]           count;
    logic [31:0]           rd_mux;
    logic                  wr_commit;
    logic                  rd_load;
    logic                  wr_ctrl;
    logic                  wr_load;
    logic                  wr_count;
    logic                  wr_status;
    logic                  tick;
    logic                  if_set;
    logic                  unused_bits;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (psel && !penable) state_next = SETUP;
            SETUP: begin
                if (!psel)         state_next = IDLE;
                else if (penable)  state_next = ACCESS;
            end
            ACCESS:  state_next = (psel && !penable) ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writes land only on the SETUP->ACCESS transition; reads sample on entry to SETUP.
    assign wr_commit = (state == SETUP) && psel && penable && pwrite;
    assign rd_load   = (state != SETUP) && psel && !penable && !pwrite;
    assign wr_ctrl   = wr_commit && (paddr[3:2] == 2'd0);
    assign wr_load   = wr_commit && (paddr[3:2] == 2'd1);
    assign wr_count  = wr_commit && (paddr[3:2] == 2'd2);
    assign wr_status = wr_commit && (paddr[3:2] == 2'd3);

    assign tick   = en && (psc_cnt == prescale);
    assign if_set = tick && (count == 32'd1);

    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:8+PRESCALE_W], pwdata[7:3]};

    always_comb begin
        rd_mux = '0;
        case (paddr[3:2])
            2'd0: begin
                rd_mux[0]               = en;
                rd_mux[1]               = reload;
                rd_mux[2]               = ie;
                rd_mux[8 +: PRESCALE_W] = prescale;
            end
            2'd1:    rd_mux = load;
            2'd2:    rd_mux = count;
            default: rd_mux[0] = if_flag;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)                   psc_cnt <= '0;
        else if (wr_ctrl || !en || tick) psc_cnt <= '0;
        else                            psc_cnt <= psc_cnt + PRESCALE_W'(1);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            ie       <= 1'b0;
            prescale <= '0;
        end else if (wr_ctrl) begin
            en       <= pwdata[0];
            reload   <= pwdata[1];
            ie       <= pwdata[2];
            prescale <= pwdata[8 +: PRESCALE_W];
        end else if (tick && (count <= 32'd1) && !reload) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)     load <= '0;
        else if (wr_load) load <= pwdata;
    end

    // Terminal count saturates at 0: reload or park, never wrap.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            count <= '0;
        end else if (wr_count) begin
            count <= pwdata;
        end else if (tick) begin
            if (count > 32'd1) count <= count - 32'd1;
            else if (reload)   count <= load;
            else               count <= '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)                     if_flag <= 1'b0;
        else if (if_set)                  if_flag <= 1'b1;
        else if (wr_status && pwdata[0])  if_flag <= 1'b0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            irq    <= 1'b0;
            prdata <= '0;
        end else begin
            irq <= if_flag & ie;
            if (rd_load) prdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: directed scenarios with literal expectations plus a
// randomized APB stream, both checked every cycle against a behavioural timer model.
module tb_apb_timer_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        irq;

    // Bench intent: this cycle is the access phase of a legal write / setup of a read.
    logic        tb_wr;
    logic        tb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_en, m_reload, m_ie, m_if, m_irq;
    logic [7:0]  m_prescale;
    int unsigned m_psc;
    logic [31:0] m_load, m_count, m_prdata;

    apb_timer_slave #(.PRESCALE_W(8)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {16'd0, m_prescale, 5'd0, m_ie, m_reload, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {31'd0, m_if};
        endcase
    endfunction

    // Timer model: a tick happens every (prescale+1) enabled cycles; a tick either
    // decrements or, at count 0/1, expires (flag on 1, then reload or stop).
    always @(posedge hclk or negedge hresetn) begin : model
        logic        tick_now;
        logic        expire;
        logic [31:0] nxt_count;
        logic        nxt_en;
        logic        nxt_if;
        if (!hresetn) begin
            m_en = 0; m_reload = 0; m_ie = 0; m_if = 0; m_irq = 0;
            m_prescale = 0; m_psc = 0; m_load = 0; m_count = 0; m_prdata = 0;
        end else begin
            tick_now = m_en && (m_psc == 32'(m_prescale));
            expire   = tick_now && (m_count < 2);
            if (tb_rd) m_prdata = m_reg(paddr[3:2]);
            m_irq     = m_if && m_ie;
            nxt_count = m_count;
            nxt_en    = m_en;
            nxt_if    = m_if;
            if (tick_now && !expire) nxt_count = m_count - 1;
            if (expire) begin
                if (m_count == 1) nxt_if = 1'b1;
                nxt_count = m_reload ? m_load : 32'd0;
                nxt_en    = m_reload;
            end
            if (tb_wr && paddr[3:2] == 2'd3 && pwdata[0] && !(expire && m_count == 1))
                nxt_if = 1'b0;
            if (tb_wr && paddr[3:2] == 2'd2) nxt_count = pwdata;
            m_psc = (m_en && !tick_now) ? m_psc + 1 : 0;
            if (tb_wr && paddr[3:2] == 2'd0) begin
                nxt_en     = pwdata[0];
                m_reload   = pwdata[1];
                m_ie       = pwdata[2];
                m_prescale = pwdata[15:8];
                m_psc      = 0;
            end
            if (tb_wr && paddr[3:2] == 2'd1) m_load = pwdata;
            m_count = nxt_count;
            m_en    = nxt_en;
            m_if    = nxt_if;
        end
    end

    always @(negedge hclk) begin
        check("prdata_vs_model", prdata, m_prdata);
        check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge hclk);
            psel = 0; penable = 0; pwrite = 0; tb_wr = 0; tb_rd = 0;
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge hclk);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d; tb_wr = 0; tb_rd = 0;
        @(negedge hclk);
        penable = 1; tb_wr = 1;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge hclk);
        psel = 1; penable = 0; pwrite = 0; paddr = a; tb_wr = 0; tb_rd = 1;
        @(negedge hclk);
        penable = 1; tb_rd = 0;
        d = prdata;
    endtask

    task automatic apb_rogue(input logic [31:0] a, input logic [31:0] d);
        @(negedge hclk);
        psel = 1; penable = 1; pwrite = 1; paddr = a; pwdata = d; tb_wr = 0; tb_rd = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        hresetn = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        tb_wr = 0; tb_rd = 0;
        repeat (3) @(negedge hclk);
        check("reset_prdata", prdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        hresetn = 1;
        idle(1);
        for (int k = 0; k < 4; k++) begin
            apb_read(32'(k) << 2, rd);
            check("reset_reg", rd, 32'd0);
        end

        // One-shot at PRESCALE=0 with IE
        apb_write(32'h4, 32'd3);
        apb_write(32'h8, 32'd3);
        apb_write(32'h0, 32'h5);
        apb_read(32'h8, rd);  check("oneshot_count_a", rd, 32'd3);
        apb_read(32'h8, rd);  check("oneshot_count_b", rd, 32'd1);
        check("oneshot_irq_lag", {31'd0, irq}, 32'd0);
        apb_read(32'h8, rd);  check("oneshot_count_c", rd, 32'd0);
        check("oneshot_irq", {31'd0, irq}, 32'd1);
        apb_read(32'h0, rd);  check("oneshot_ctrl_en_off", rd, 32'h4);
        apb_read(32'hC, rd);  check("oneshot_status", rd, 32'd1);

        // W1C, then clear colliding with the 1->0 tick
        apb_write(32'hC, 32'h1);
        idle(2);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        apb_read(32'hC, rd);  check("w1c_status", rd, 32'd0);
        apb_write(32'h8, 32'd1);
        apb_write(32'h0, 32'h505);
        idle(4);
        apb_write(32'hC, 32'h1);
        apb_read(32'hC, rd);  check("set_beats_clear", rd, 32'd1);
        apb_read(32'h8, rd);  check("collide_count", rd, 32'd0);
        apb_read(32'h0, rd);  check("collide_ctrl", rd, 32'h504);

        // Auto-reload at PRESCALE=2, IE=0
        apb_write(32'hC, 32'h1);
        apb_write(32'h4, 32'd2);
        apb_write(32'h8, 32'd2);
        apb_write(32'h0, 32'h203);
        idle(20);
        apb_read(32'hC, rd);  check("reload_status", rd, 32'd1);
        check("reload_irq_masked", {31'd0, irq}, 32'd0);
        apb_read(32'h0, rd);  check("reload_ctrl", rd, 32'h203);
        for (int k = 0; k < 3; k++) begin
            apb_read(32'h8, rd);
            check("reload_count_range", {31'd0, (rd == 32'd1) || (rd == 32'd2)}, 32'd1);
            idle(k);
        end
        apb_read(32'hFFFF_FF0C, rd);  check("status_alias_addr", rd, 32'd1);
        apb_write(32'h0, 32'h0);

        // COUNT write on a tick cycle, then reset mid-write
        apb_write(32'h8, 32'd100);
        apb_write(32'h0, 32'h1);
        apb_write(32'h8, 32'h10);
        apb_read(32'h8, rd);  check("count_write_wins", rd, 32'h10);
        @(negedge hclk);
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h4; pwdata = 32'h55; tb_wr = 0; tb_rd = 0;
        @(negedge hclk);
        penable = 1; tb_wr = 1;
        #2 hresetn = 0;
        idle(2);
        hresetn = 1;
        idle(1);
        for (int k = 0; k < 4; k++) begin
            apb_read(32'(k) << 2, rd);
            check("post_reset_reg", rd, 32'd0);
        end

        // Access phase without setup must not write
        apb_write(32'h4, 32'h1234);
        idle(1);
        apb_rogue(32'h4, 32'hDEAD);
        idle(1);
        apb_read(32'h4, rd);  check("rogue_load", rd, 32'h1234);
        apb_rogue(32'h0, 32'h7);
        apb_read(32'h0, rd);  check("rogue_ctrl", rd, 32'd0);

        // Randomized APB traffic
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 9));
            a  = $urandom;
            case (a[3:2])
                2'd0:    d = ($urandom & 32'hFFFF_00FF) | ($urandom_range(0, 3) << 8);
                2'd3:    d = $urandom;
                default: d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 6);
            endcase
            if (op < 5)      apb_write(a, d);
            else if (op < 9) apb_read(a, rd);
            else             apb_rogue(a, d);
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_timer_slave.md
APB_TIMER_SLAVE -- requirements
Module: apb_timer_slave

Interface
REQ-001 Parameter PRESCALE_W, 8, width of the prescaler field and prescaler counter.
REQ-002 hclk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 hresetn  input  1  reset; asynchronous assert, active-low.
REQ-004 psel  input  1  APB select from the upstream AHB-to-APB bridge.
REQ-005 penable  input  1  APB access-phase strobe.
REQ-006 pwrite  input  1  APB direction: 1 = write, 0 = read.
REQ-007 paddr  input  32  APB address; only paddr[3:2] SHALL be decoded, all other bits ignored.
REQ-008 pwdata  input  32  APB write data.
REQ-009 prdata  output  32  APB read data, registered.
REQ-010 irq  output  1  interrupt, level, registered.

Function
REQ-011 The block SHALL be a zero-wait-state APB slave with no pready and no pslverr, because the upstream bridge completes every transfer in exactly one setup cycle plus one access cycle.
REQ-012 The APB tracker FSM SHALL have the states IDLE, SETUP and ACCESS: IDLE->SETUP on psel&!penable; SETUP->ACCESS on psel&penable; ACCESS->SETUP on psel&!penable; ACCESS->IDLE otherwise; SETUP->IDLE on !psel.
REQ-013 A write SHALL commit only at the edge that ends ACCESS when pwrite=1; psel&penable seen outside SETUP->ACCESS SHALL be ignored, with no register change.
REQ-014 A read SHALL load prdata at the edge that ends SETUP, so prdata is stable for the whole access cycle; prdata SHALL hold otherwise.
REQ-015 Register map by paddr[3:2]:
  - 0 CTRL: [0] EN, [1] RELOAD, [2] IE, [8+:PRESCALE_W] PRESCALE
  - 1 LOAD: 32-bit reload value
  - 2 COUNT: current count (R/W)
  - 3 STATUS: [0] IF, write-1-to-clear
REQ-016 Unused register bits SHALL read 0 and ignore writes.
REQ-017 A prescaler counter SHALL count 0..PRESCALE while EN=1 and emit a one-cycle tick when it equals PRESCALE, then wrap to 0; tick period = PRESCALE+1 cycles.
REQ-018 When EN=0 the prescaler SHALL hold at 0; any CTRL write SHALL clear the prescaler to 0.
REQ-019 On a tick:
  - COUNT>1: COUNT decrements by 1.
  - COUNT==1: IF set; COUNT<=LOAD if RELOAD=1; else COUNT<=0 and EN cleared.
  - COUNT==0: no IF; COUNT<=LOAD if RELOAD=1; else EN cleared.
REQ-020 COUNT SHALL never wrap below 0 (no 0->0xFFFFFFFF).
REQ-021 An APB write to COUNT in the same cycle as a tick SHALL take priority over the decrement.
REQ-022 An IF set event in the same cycle as a STATUS write-1-clear SHALL leave IF=1 (set wins).
REQ-023 An EN auto-clear in the same cycle as a CTRL write SHALL take the written value.
REQ-024 irq SHALL be registered IF&IE and SHALL update one cycle after either changes.
REQ-025 A read of COUNT SHALL return the value held at the SETUP-ending edge.

Reset
REQ-026 While hresetn=0, the following SHALL be 0 and the FSM SHALL be IDLE: CTRL, LOAD, COUNT, IF, the prescaler, prdata and irq.
REQ-027 Reset asserted mid-transfer or mid-count SHALL abort immediately with no partial write; after release, the first valid SETUP SHALL be accepted.

Verification
REQ-028 Write LOAD=3, COUNT=3, CTRL=0x0000_0005 (EN, IE, PRESCALE=0) -> COUNT 2,1,0 on successive cycles; IF=1 at the edge reaching 0; irq=1 one cycle later; EN reads 0.
REQ-029 Set LOAD=2, COUNT=2, CTRL=0x0000_0203 (EN, RELOAD, PRESCALE=2) -> tick every 3 cycles; COUNT sequence 2,1,2,1...; IF set on every 1->reload transition; irq stays 0 (IE=0).
REQ-030 Set IF=1 and IE=1, write STATUS=0x1 -> IF=0 and irq=0 one cycle later; repeat the clear on the same cycle as a 1->0 tick -> IF stays 1.
REQ-031 Read COUNT while running at PRESCALE=0 -> prdata equals the COUNT value at the SETUP edge and is stable during penable; read of STATUS with paddr=0xFFFF_FF0C -> returns the STATUS contents (upper bits ignored).
REQ-032 Write COUNT=0x10 on a tick cycle -> COUNT=0x10 (no decrement that cycle); assert hresetn=0 mid-write -> all registers read 0 after release.
REQ-033 Drive psel=1, penable=1 with no preceding setup cycle and pwrite=1 -> no register changes.
